// File: rtl/scfifo_s_showahead_m20k_r_pkg.sv
// Shared constants for the show-ahead M20K FIFO: RAM family names,
// parameter range limits and the default usable capacity.
package scfifo_pkg;

   localparam string FAMILY_AGILEX = "Agilex";
   localparam string FAMILY_S10    = "S10";
   localparam string FAMILY_OTHER  = "Other";

   localparam int SCFIFO_MIN_LOG_DEPTH = 4;
   localparam int SCFIFO_MAX_LOG_DEPTH = 11;
   localparam int SCFIFO_MAX_WIDTH     = 40;
   localparam int SCFIFO_MIN_NUM_WORDS = 3;

   // One RAM slot is sacrificed so pointer distance never aliases to zero.
   function automatic int scfifo_num_words(input int log_depth);
      return (1 << log_depth) - 1;
   endfunction

endpackage

// File: rtl/scfifo_s_showahead_m20k_r_ram.sv
// Simple dual-port M20K wrapper: one write port, one registered read port.
// Read data appears one edge after re_i and holds while re_i is low.
module generic_m20k
   import scfifo_pkg::*;
#(
   parameter int    WIDTH      = 16,
   parameter int    ADDR_WIDTH = 5,
   parameter string FAMILY     = FAMILY_S10
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [WIDTH-1:0]      wdata_i,
   input  logic                  re_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i,
   output logic [WIDTH-1:0]      rdata_o
);

   logic [WIDTH-1:0] mem_q [2**ADDR_WIDTH];
   logic [WIDTH-1:0] rdata_q;

   if (FAMILY != FAMILY_AGILEX && FAMILY != FAMILY_S10 && FAMILY != FAMILY_OTHER) begin : g_bad_family
      $error("generic_m20k: unsupported FAMILY %s", FAMILY);
   end

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/scfifo_s_showahead_m20k_r.sv
// Single-clock show-ahead FIFO on one M20K with a two-stage prefetch (RAM output, q).
// Write-to-q latency 3 edges; full drops writes, empty drops reads, both set sticky errors.
module scfifo_s_showahead_m20k_r
   import scfifo_pkg::*;
#(
   parameter int    LOG_DEPTH          = 5,
   parameter int    WIDTH              = 16,
   parameter int    NUM_WORDS          = scfifo_num_words(LOG_DEPTH),
   parameter int    ALMOST_FULL_VALUE  = 24,
   parameter int    ALMOST_EMPTY_VALUE = 2,
   parameter string FAMILY             = FAMILY_S10
) (
   input  logic                 clock,
   input  logic                 sclr,
   input  logic [WIDTH-1:0]     data,
   input  logic                 wrreq,
   input  logic                 rdreq,
   output logic [WIDTH-1:0]     q,
   output logic [LOG_DEPTH-1:0] usedw,
   output logic                 empty,
   output logic                 full,
   output logic                 almost_empty,
   output logic                 almost_full,
   output logic                 overflow,
   output logic                 underflow
);

   if (LOG_DEPTH < SCFIFO_MIN_LOG_DEPTH || LOG_DEPTH > SCFIFO_MAX_LOG_DEPTH) begin : g_bad_depth
      $error("scfifo: LOG_DEPTH %0d out of range", LOG_DEPTH);
   end
   if (WIDTH < 1 || WIDTH > SCFIFO_MAX_WIDTH) begin : g_bad_width
      $error("scfifo: WIDTH %0d out of range", WIDTH);
   end
   if (NUM_WORDS < SCFIFO_MIN_NUM_WORDS || NUM_WORDS > scfifo_num_words(LOG_DEPTH)) begin : g_bad_words
      $error("scfifo: NUM_WORDS %0d out of range", NUM_WORDS);
   end
   if (ALMOST_FULL_VALUE < 1 || ALMOST_FULL_VALUE > NUM_WORDS) begin : g_bad_af
      $error("scfifo: ALMOST_FULL_VALUE %0d out of range", ALMOST_FULL_VALUE);
   end
   if (ALMOST_EMPTY_VALUE < 1 || ALMOST_EMPTY_VALUE > NUM_WORDS) begin : g_bad_ae
      $error("scfifo: ALMOST_EMPTY_VALUE %0d out of range", ALMOST_EMPTY_VALUE);
   end

   localparam logic [LOG_DEPTH-1:0] NUM_WORDS_W = LOG_DEPTH'(NUM_WORDS);
   localparam logic [LOG_DEPTH-1:0] AF_W        = LOG_DEPTH'(ALMOST_FULL_VALUE);
   localparam logic [LOG_DEPTH-1:0] AE_W        = LOG_DEPTH'(ALMOST_EMPTY_VALUE);

   logic                 wr_acc, rd_acc, avail, q_free, s1_to_q, issue;
   logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d, wr_vis_q, rd_ptr_q, rd_ptr_d;
   logic [LOG_DEPTH-1:0] usedw_q, usedw_d;
   logic                 s1_vld_q, s1_vld_d, q_vld_q, q_vld_d;
   logic [WIDTH-1:0]     q_dat_q, q_dat_d, ram_rdata;
   logic                 full_q, full_d, aempty_q, aempty_d, afull_q, afull_d;
   logic                 ovf_q, ovf_d, udf_q, udf_d;

   generic_m20k #(
      .WIDTH      (WIDTH),
      .ADDR_WIDTH (LOG_DEPTH),
      .FAMILY     (FAMILY)
   ) u_ram (
      .clk_i   (clock),
      .we_i    (wr_acc),
      .waddr_i (wr_ptr_q),
      .wdata_i (data),
      .re_i    (issue),
      .raddr_i (rd_ptr_q),
      .rdata_o (ram_rdata)
   );

   // wr_vis_q lags wr_ptr_q by one edge so a word is only fetched after it
   // has settled in the RAM; this sets the 3-edge write-to-q latency.
   always_comb begin
      wr_acc  = wrreq && !full_q;
      rd_acc  = rdreq && q_vld_q;
      avail   = (wr_vis_q != rd_ptr_q);
      q_free  = !q_vld_q || rd_acc;
      s1_to_q = s1_vld_q && q_free;
      issue   = avail && (!s1_vld_q || q_free);
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q + LOG_DEPTH'(wr_acc);
      rd_ptr_d = rd_ptr_q + LOG_DEPTH'(issue);
      usedw_d  = usedw_q + LOG_DEPTH'(wr_acc) - LOG_DEPTH'(rd_acc);

      s1_vld_d = s1_vld_q;
      if (issue) begin
         s1_vld_d = 1'b1;
      end else if (s1_to_q) begin
         s1_vld_d = 1'b0;
      end

      q_vld_d = q_vld_q;
      q_dat_d = q_dat_q;
      if (s1_to_q) begin
         q_vld_d = 1'b1;
         q_dat_d = ram_rdata;
      end else if (rd_acc) begin
         q_vld_d = 1'b0;
      end

      full_d   = (usedw_d == NUM_WORDS_W);
      afull_d  = (usedw_d >= AF_W);
      aempty_d = (usedw_d < AE_W);
      ovf_d    = ovf_q || (wrreq && full_q);
      udf_d    = udf_q || (rdreq && !q_vld_q);
   end

   always_ff @(posedge clock) begin
      if (sclr) begin
         wr_ptr_q <= '0;
         wr_vis_q <= '0;
         rd_ptr_q <= '0;
         usedw_q  <= '0;
         s1_vld_q <= 1'b0;
         q_vld_q  <= 1'b0;
         q_dat_q  <= '0;
         full_q   <= 1'b0;
         afull_q  <= 1'b0;
         aempty_q <= 1'b1;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         wr_vis_q <= wr_ptr_q;
         rd_ptr_q <= rd_ptr_d;
         usedw_q  <= usedw_d;
         s1_vld_q <= s1_vld_d;
         q_vld_q  <= q_vld_d;
         q_dat_q  <= q_dat_d;
         full_q   <= full_d;
         afull_q  <= afull_d;
         aempty_q <= aempty_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   assign q            = q_dat_q;
   assign usedw        = usedw_q;
   assign empty        = !q_vld_q;
   assign full         = full_q;
   assign almost_empty = aempty_q;
   assign almost_full  = afull_q;
   assign overflow     = ovf_q;
   assign underflow    = udf_q;

endmodule

// File: tb/tb_scfifo_s_showahead_m20k_r.sv
// Directed bench for the show-ahead M20K FIFO with hand-computed expectations.
module tb_scfifo_s_showahead_m20k_r;

   localparam int LD = 5;
   localparam int W  = 16;
   localparam int NW = 31;

   logic          clock = 1'b0;
   logic          sclr, wrreq, rdreq;
   logic [W-1:0]  data;
   logic [W-1:0]  q;
   logic [LD-1:0] usedw;
   logic          empty, full, almost_empty, almost_full, overflow, underflow;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   scfifo_s_showahead_m20k_r #(
      .LOG_DEPTH          (LD),
      .WIDTH              (W),
      .NUM_WORDS          (NW),
      .ALMOST_FULL_VALUE  (24),
      .ALMOST_EMPTY_VALUE (2),
      .FAMILY             ("S10")
   ) dut (
      .clock        (clock),
      .sclr         (sclr),
      .data         (data),
      .wrreq        (wrreq),
      .rdreq        (rdreq),
      .q            (q),
      .usedw        (usedw),
      .empty        (empty),
      .full         (full),
      .almost_empty (almost_empty),
      .almost_full  (almost_full),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      sclr  = 1'b1;
      wrreq = 1'b0;
      rdreq = 1'b0;
      data  = '0;
      tick();
      sclr  = 1'b0;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_usedw"}, usedw, 0);
      chk({tag, "_q"}, q, 0);
      chk({tag, "_empty"}, empty, 1);
      chk({tag, "_full"}, full, 0);
      chk({tag, "_aempty"}, almost_empty, 1);
      chk({tag, "_afull"}, almost_full, 0);
      chk({tag, "_ovf"}, overflow, 0);
      chk({tag, "_udf"}, underflow, 0);
   endtask

   task automatic push(input int val);
      data  = W'(val);
      wrreq = 1'b1;
      tick();
      wrreq = 1'b0;
   endtask

   // Waits a bounded time for a head word, checks it, then consumes it.
   task automatic pop_word(input string tag, input int exp);
      int n = 0;
      while (empty && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_ready"}, empty, 0);
      chk({tag, "_q"}, q, exp);
      rdreq = 1'b1;
      tick();
      rdreq = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      sclr  = 1'b0;
      wrreq = 1'b0;
      rdreq = 1'b0;
      data  = '0;

      // Reset, then a single write travels to q in three edges.
      do_reset();
      chk_reset_state("rst");
      push(16'h1234);
      chk("w1_usedw", usedw, 1);
      chk("w1_empty_e1", empty, 1);
      tick();
      chk("w1_empty_e2", empty, 1);
      tick();
      chk("w1_empty_e3", empty, 1);
      tick();
      chk("w1_empty_e4", empty, 0);
      chk("w1_q", q, 16'h1234);
      chk("w1_aempty", almost_empty, 1);

      // Fill to capacity with no reads; flags follow usedw.
      do_reset();
      for (int i = 0; i < NW; i++) begin
         push(i);
         chk($sformatf("fill%0d_usedw", i), usedw, i + 1);
         chk($sformatf("fill%0d_afull", i), almost_full, (i + 1 >= 24) ? 1 : 0);
         chk($sformatf("fill%0d_full", i), full, (i + 1 == NW) ? 1 : 0);
         chk($sformatf("fill%0d_aempty", i), almost_empty, (i + 1 < 2) ? 1 : 0);
      end
      chk("fill_ovf_before", overflow, 0);
      push(16'h7777);
      chk("ovf_set", overflow, 1);
      chk("ovf_usedw", usedw, NW);
      chk("ovf_full", full, 1);
      tick();
      tick();
      chk("fill_head_q", q, 0);
      chk("fill_head_empty", empty, 0);

      // Full with simultaneous read and write: read wins, write is dropped.
      do_reset();
      for (int i = 0; i < NW; i++) push(i);
      tick();
      tick();
      tick();
      chk("fr_ovf_before", overflow, 0);
      chk("fr_full_before", full, 1);
      data  = 16'h5555;
      wrreq = 1'b1;
      rdreq = 1'b1;
      tick();
      wrreq = 1'b0;
      rdreq = 1'b0;
      chk("fr_usedw", usedw, NW - 1);
      chk("fr_full", full, 0);
      chk("fr_ovf", overflow, 1);
      chk("fr_q_next", q, 1);
      chk("fr_empty", empty, 0);
      for (int k = 1; k < NW; k++) pop_word($sformatf("fr_drain%0d", k), k);
      tick();
      tick();
      tick();
      chk("fr_after_empty", empty, 1);
      chk("fr_after_usedw", usedw, 0);
      chk("fr_after_udf", underflow, 0);

      // Streaming: 4-word preload then read and write every cycle.
      do_reset();
      for (int i = 0; i < 4; i++) push(i);
      tick();
      tick();
      tick();
      tick();
      chk("st_pre_usedw", usedw, 4);
      chk("st_pre_q", q, 0);
      for (int i = 0; i < 96; i++) begin
         data  = W'(i + 4);
         wrreq = 1'b1;
         rdreq = 1'b1;
         chk($sformatf("st%0d_empty", i), empty, 0);
         chk($sformatf("st%0d_q", i), q, i);
         tick();
         chk($sformatf("st%0d_usedw", i), usedw, 4);
      end
      wrreq = 1'b0;
      rdreq = 1'b0;
      for (int i = 96; i < 100; i++) pop_word($sformatf("st_tail%0d", i), i);
      chk("st_end_usedw", usedw, 0);

      // Read against empty sets a sticky underflow.
      do_reset();
      rdreq = 1'b1;
      tick();
      rdreq = 1'b0;
      chk("ue_udf", underflow, 1);
      chk("ue_usedw", usedw, 0);
      chk("ue_empty", empty, 1);
      push(16'h00A5);
      tick();
      tick();
      tick();
      chk("ue_udf_hold", underflow, 1);
      chk("ue_q", q, 16'h00A5);
      do_reset();
      chk("ue_udf_clr", underflow, 0);

      // Mid-stream sclr discards everything in flight.
      do_reset();
      rdreq = 1'b1;
      tick();
      rdreq = 1'b0;
      for (int i = 0; i < 10; i++) push(16'h0100 + i);
      tick();
      tick();
      tick();
      rdreq = 1'b1;
      tick();
      tick();
      chk("ms_q_before", q, 16'h0102);
      chk("ms_udf_before", underflow, 1);
      sclr  = 1'b1;
      wrreq = 1'b1;
      data  = 16'hDEAD;
      tick();
      sclr  = 1'b0;
      wrreq = 1'b0;
      rdreq = 1'b0;
      chk_reset_state("ms");
      push(16'hBEEF);
      chk("ms_w_usedw", usedw, 1);
      chk("ms_w_empty1", empty, 1);
      tick();
      chk("ms_w_empty2", empty, 1);
      tick();
      chk("ms_w_empty3", empty, 1);
      tick();
      chk("ms_w_empty4", empty, 0);
      chk("ms_w_q", q, 16'hBEEF);
      tick();
      tick();
      chk("ms_w_q_hold", q, 16'hBEEF);
      pop_word("ms_pop", 16'hBEEF);
      tick();
      tick();
      tick();
      chk("ms_final_empty", empty, 1);
      chk("ms_final_usedw", usedw, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
